// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - weighted round-robin arbiter with packet-granular grants
//
// Grants one requester at a time with a registered one-hot grant. The owner
// keeps the bus for up to `weight` whole packets (a packet ends on the beat
// carrying last_i). A packet in flight is never cut off. After a release the
// search restarts just past the previous owner, so the owner can only win
// again when nobody else is asking.

module weighted_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        allow_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_i,
  input  logic                        ready_i,
  input  logic                        last_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [IDX_W-1:0]            gnt_idx_o,
  output logic                        valid_o,
  output logic [WEIGHT_W-1:0]         credit_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic                pkt_q;

  logic                xfer;
  logic                release_now;
  logic                grant_new;
  logic [IDX_W-1:0]    next_ptr;
  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [WEIGHT_W-1:0] win_weight;
  logic [WEIGHT_W-1:0] win_credit;

  assign xfer     = (state_q == GRANT) & ready_i;
  assign next_ptr = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Release on the last packet of the quantum, or when the owner is idle
  // between packets and has stopped requesting.
  always_comb begin
    release_now = 1'b0;
    if (state_q == GRANT) begin
      release_now = (xfer & last_i & (credit_q == WEIGHT_W'(1))) |
                    (~pkt_q & ~req_i[idx_q] & ~xfer);
    end
  end

  // Round-robin search: from ptr when idle, from just past the owner on release.
  always_comb begin
    int cand;
    cand      = 0;
    base      = (state_q == GRANT) ? next_ptr : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(base) + i) % NUM_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // A zero weight still buys the winner one packet.
  always_comb begin
    win_weight = weight_i[win_idx*WEIGHT_W +: WEIGHT_W];
    win_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
  end

  assign grant_new = allow_i & win_found & ((state_q == IDLE) | release_now);

  // Grant FSM: issue, hold, count packets and release.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      pkt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_new) begin
            state_q  <= GRANT;
            gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            idx_q    <= win_idx;
            credit_q <= win_credit;
            pkt_q    <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_q <= next_ptr;
            pkt_q <= 1'b0;
            if (grant_new) begin
              gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
              idx_q    <= win_idx;
              credit_q <= win_credit;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= '0;
              credit_q <= '0;
            end
          end else if (xfer) begin
            if (last_i) begin
              pkt_q    <= 1'b0;
              credit_q <= credit_q - 1'b1;
            end else begin
              pkt_q    <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign valid_o   = (state_q == GRANT);
  assign credit_o  = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - scoreboard bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        allow_i;
  logic [3:0]  req_i;
  logic [15:0] weight_i;
  logic        ready_i;
  logic        last_i;
  logic [3:0]  gnt_o;
  logic [1:0]  gnt_idx_o;
  logic        valid_o;
  logic [3:0]  credit_o;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  weighted_rr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .allow_i(allow_i), .req_i(req_i),
    .weight_i(weight_i), .ready_i(ready_i), .last_i(last_i),
    .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .valid_o(valid_o), .credit_o(credit_o)
  );

  // expected output word {valid, gnt[3:0], idx[1:0], credit[3:0]}
  function automatic logic [10:0] ex(input logic v, input logic [3:0] g,
                                     input logic [1:0] i, input logic [3:0] c);
    return {v, g, i, c};
  endfunction

  // idx is only meaningful while a grant is expected
  function automatic logic [10:0] obs(input logic v_exp);
    return {valid_o, gnt_o, v_exp ? gnt_idx_o : 2'b00, credit_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // stimulus word {req[3:0], allow, ready, last}
  task automatic drive(input logic [6:0] s);
    {req_i, allow_i, ready_i, last_i} = s;
  endtask

  task automatic apply_reset();
    arst_i = 1'b1;
    drive(7'b0000_0_0_0);
    tick();
    tick();
    arst_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b expected 0000", gnt_o); end
    checks++; if (gnt_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d expected 0", gnt_idx_o); end
    checks++; if (credit_o !== 4'd0) begin errors++; $display("FAIL reset_credit got %0d expected 0", credit_o); end
    drive(7'b1111_1_1_1);
    tick();
    checks++;
    if ({valid_o, gnt_o, gnt_idx_o, credit_o} !== 11'd0) begin
      errors++; $display("FAIL reset_held got %h expected 000", {valid_o, gnt_o, gnt_idx_o, credit_o});
    end
  endtask

  task automatic test_allow_block();
    logic [17:0] tbl [5];
    logic [10:0] e;
    weight_i = 16'h1111;
    apply_reset();
    tbl = '{{7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_1_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL allow_block step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_fairness();
    logic [17:0] tbl [6];
    logic [10:0] e;
    weight_i = 16'h1111;
    apply_reset();
    tbl = '{{7'b1111_1_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b1111_1_1_1, ex(1, 4'b0010, 1, 1)},
            {7'b1111_1_1_1, ex(1, 4'b0100, 2, 1)},
            {7'b1111_1_1_1, ex(1, 4'b1000, 3, 1)},
            {7'b1111_1_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL fairness step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_weighting();
    logic [17:0] tbl [9];
    logic [10:0] e;
    weight_i = 16'h1113;
    apply_reset();
    tbl = '{{7'b0011_1_1_1, ex(1, 4'b0001, 0, 3)},
            {7'b0011_1_1_1, ex(1, 4'b0001, 0, 2)},
            {7'b0011_1_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b0011_1_1_1, ex(1, 4'b0010, 1, 1)},
            {7'b0011_1_1_1, ex(1, 4'b0001, 0, 3)},
            {7'b0011_1_1_1, ex(1, 4'b0001, 0, 2)},
            {7'b0011_1_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b0011_1_1_1, ex(1, 4'b0010, 1, 1)},
            {7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL weighting step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_packet_lock();
    logic [17:0] tbl [7];
    logic [10:0] e;
    weight_i = 16'h1111;
    apply_reset();
    tbl = '{{7'b0100_1_0_0, ex(1, 4'b0100, 2, 1)},
            {7'b0100_1_1_0, ex(1, 4'b0100, 2, 1)},
            {7'b1011_1_1_0, ex(1, 4'b0100, 2, 1)},
            {7'b1011_1_0_0, ex(1, 4'b0100, 2, 1)},
            {7'b1011_1_1_0, ex(1, 4'b0100, 2, 1)},
            {7'b1011_1_1_1, ex(1, 4'b1000, 3, 1)},
            {7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL packet_lock step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_stall_zero_weight();
    logic [17:0] tbl [11];
    logic [10:0] e;
    weight_i = 16'h0111;
    apply_reset();
    tbl = '{{7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b1000_1_0_0, ex(1, 4'b1000, 3, 1)},
            {7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b0010_1_0_0, ex(1, 4'b0010, 1, 1)},
            {7'b0000_1_0_0, ex(0, 4'b0000, 0, 0)},
            {7'b1111_1_0_0, ex(1, 4'b0100, 2, 1)},
            {7'b0000_1_0_0, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL stall_zero_weight step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_allow_drop();
    logic [17:0] tbl [11];
    logic [10:0] e;
    weight_i = 16'h1112;
    apply_reset();
    tbl = '{{7'b1111_1_1_1, ex(1, 4'b0001, 0, 2)},
            {7'b1111_0_1_1, ex(1, 4'b0001, 0, 1)},
            {7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_0_1_1, ex(0, 4'b0000, 0, 0)},
            {7'b1111_1_1_1, ex(1, 4'b0010, 1, 1)},
            {7'b1111_1_1_1, ex(1, 4'b0100, 2, 1)},
            {7'b1111_1_1_1, ex(1, 4'b1000, 3, 1)},
            {7'b1111_1_1_1, ex(1, 4'b0001, 0, 5)},
            {7'b0000_1_1_1, ex(1, 4'b0001, 0, 4)},
            {7'b0000_1_0_0, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      if (i == 1) weight_i = 16'h1115;
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL allow_drop step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [18:0] tbl [5];
    logic [10:0] e;
    weight_i = 16'h1111;
    apply_reset();
    tbl = '{{1'b0, 7'b0100_1_0_0, ex(1, 4'b0100, 2, 1)},
            {1'b0, 7'b0100_1_1_0, ex(1, 4'b0100, 2, 1)},
            {1'b1, 7'b1111_1_1_1, ex(0, 4'b0000, 0, 0)},
            {1'b0, 7'b1111_1_1_1, ex(1, 4'b0001, 0, 1)},
            {1'b0, 7'b0000_1_1_1, ex(0, 4'b0000, 0, 0)}};
    foreach (tbl[i]) begin
      if (tbl[i][18] && !arst_i) begin
        arst_i = 1'b1;
        #1;
        checks++;
        if ({valid_o, gnt_o, gnt_idx_o, credit_o} !== 11'd0) begin
          errors++; $display("FAIL reset_immediate got %h expected 000", {valid_o, gnt_o, gnt_idx_o, credit_o});
        end
      end
      arst_i = tbl[i][18];
      drive(tbl[i][17:11]);
      exp_q.push_back(tbl[i][10:0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs(e[10]) !== e) begin errors++; $display("FAIL reset_mid step %0d got %h expected %h", i, obs(e[10]), e); end
    end
  endtask

  initial begin
    arst_i   = 1'b1;
    weight_i = 16'h1111;
    drive(7'b0000_0_0_0);
    test_reset();
    test_allow_block();
    test_fairness();
    test_weighting();
    test_packet_lock();
    test_stall_zero_weight();
    test_allow_drop();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
